// File: rtl/gun_flash_ctl.sv
`default_nettype none
// ============================================================================
// Module  : gun_flash_ctl
// Purpose : Display-side half of the light-gun shot protocol. A trigger
//           request is turned into one black frame followed by
//           WHITE_FRAMES frames with the target drawn white. The
//           photodetector reply is judged and one hit or miss pulse is
//           reported per accepted shot.
// Ports   : clk               - pixel clock
//           rst_n             - asynchronous active-low reset
//           frame_start       - one-cycle pulse at first pixel of a frame
//           shot_req          - one-cycle debounced trigger pulse
//           gun_is_connected  - level, shots ignored while low
//           gun_photodetector - asynchronous level, 1 = light seen
//           blank_screen      - draw stage forces whole screen black
//           target_white      - draw stage paints target box white
//           busy              - shot sequence in progress
//           hit / miss        - one-cycle result pulses
// Revision: 1.0 - initial release
// ============================================================================
module gun_flash_ctl #(
  parameter int WHITE_FRAMES    = 1,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int DETECT_MIN      = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic shot_req,
  input  logic gun_is_connected,
  input  logic gun_photodetector,
  output logic blank_screen,
  output logic target_white,
  output logic busy,
  output logic hit,
  output logic miss
);

  // frame_cnt only ever counts 0 .. max(WHITE_FRAMES, COOLDOWN_FRAMES)-1
  localparam int c_FC_MAX = (WHITE_FRAMES > COOLDOWN_FRAMES) ? WHITE_FRAMES : COOLDOWN_FRAMES;
  localparam int c_FCW    = (c_FC_MAX < 2) ? 1 : $clog2(c_FC_MAX);
  localparam int c_LCW    = $clog2(DETECT_MIN + 1);

  localparam logic [c_FCW-1:0] c_WHITE_LAST = c_FCW'(WHITE_FRAMES - 1);
  localparam logic [c_FCW-1:0] c_COOL_LAST  =
      (COOLDOWN_FRAMES > 0) ? c_FCW'(COOLDOWN_FRAMES - 1) : '0;
  localparam logic [c_LCW-1:0] c_DETECT     = c_LCW'(DETECT_MIN);
  localparam logic [c_FCW-1:0] c_FC_ONE     = c_FCW'(1);
  localparam logic [c_LCW-1:0] c_LC_ONE     = c_LCW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_BLACK    = 3'd2,
    S_WHITE    = 3'd3,
    S_RESULT   = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_pd_sync;
  logic                   w_pd;
  logic [c_FCW-1:0]       r_frame_cnt;
  logic [c_FCW-1:0]       w_frame_cnt_nxt;
  logic [c_LCW-1:0]       r_light_cnt;
  logic [c_LCW-1:0]       w_light_cnt_nxt;
  logic                   r_dark_fail;
  logic                   w_dark_fail_nxt;
  logic                   w_hit_nxt;
  logic                   w_miss_nxt;
  logic                   r_blank;
  logic                   r_white;
  logic                   r_busy;
  logic                   r_hit;
  logic                   r_miss;

  // Photodetector is asynchronous to the pixel clock: plain shift-register
  // synchroniser, oldest stage is the usable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pd_sync <= '0;
    end else begin
      r_pd_sync <= {r_pd_sync[SYNC_STAGES-2:0], gun_photodetector};
    end
  end

  assign w_pd = r_pd_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_light_cnt_nxt = r_light_cnt;
    w_dark_fail_nxt = r_dark_fail;
    w_hit_nxt       = 1'b0;
    w_miss_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A frame_start coincident with the shot is deliberately not used:
        // ARM waits for the next one so BLACK always spans a whole frame.
        if (shot_req && gun_is_connected) begin
          w_state_nxt = S_ARM;
        end
      end

      S_ARM: begin
        w_light_cnt_nxt = '0;
        w_dark_fail_nxt = 1'b0;
        if (frame_start) begin
          w_state_nxt = S_BLACK;
        end
      end

      S_BLACK: begin
        // Light seen while the screen is black means an external lamp, not
        // the target: poison the shot.
        if (w_pd) begin
          w_dark_fail_nxt = 1'b1;
        end
        if (frame_start) begin
          w_state_nxt     = S_WHITE;
          w_frame_cnt_nxt = '0;
        end
      end

      S_WHITE: begin
        if (w_pd && (r_light_cnt != c_DETECT)) begin
          w_light_cnt_nxt = r_light_cnt + c_LC_ONE;
        end
        if (frame_start) begin
          if (r_frame_cnt == c_WHITE_LAST) begin
            w_state_nxt = S_RESULT;
            // Verdict is registered on entry so the pulse coincides with
            // the single RESULT cycle; it includes this cycle's light sample.
            if ((w_light_cnt_nxt == c_DETECT) && !r_dark_fail) begin
              w_hit_nxt = 1'b1;
            end else begin
              w_miss_nxt = 1'b1;
            end
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + c_FC_ONE;
          end
        end
      end

      S_RESULT: begin
        w_frame_cnt_nxt = '0;
        w_state_nxt     = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
      end

      S_COOLDOWN: begin
        if (frame_start) begin
          if (r_frame_cnt == c_COOL_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + c_FC_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. Outputs are decoded from the next
  // state so they are aligned with the state register itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_light_cnt <= '0;
      r_dark_fail <= 1'b0;
      r_blank     <= 1'b0;
      r_white     <= 1'b0;
      r_busy      <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_frame_cnt <= w_frame_cnt_nxt;
      r_light_cnt <= w_light_cnt_nxt;
      r_dark_fail <= w_dark_fail_nxt;
      r_blank     <= (w_state_nxt == S_BLACK);
      r_white     <= (w_state_nxt == S_WHITE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
    end
  end

  assign blank_screen = r_blank;
  assign target_white = r_white;
  assign busy         = r_busy;
  assign hit          = r_hit;
  assign miss         = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_gun_flash_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gun_flash_ctl
// Purpose : Self-checking bench for gun_flash_ctl. frame_start every 100
//           clocks, WHITE_FRAMES=1, COOLDOWN_FRAMES=2, DETECT_MIN=16.
//           Whole-shot scenarios come from a vector table; reset and
//           coincident-trigger corner cases are hand-written sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gun_flash_ctl;

  localparam int c_FRAME = 100;

  logic clk;
  logic rst_n;
  logic frame_start;
  logic shot_req;
  logic gun_is_connected;
  logic gun_photodetector;
  logic blank_screen;
  logic target_white;
  logic busy;
  logic hit;
  logic miss;

  int n_chk;
  int n_fail;
  int ph;

  gun_flash_ctl #(
    .WHITE_FRAMES    (1),
    .COOLDOWN_FRAMES (2),
    .DETECT_MIN      (16),
    .SYNC_STAGES     (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start       (frame_start),
    .shot_req          (shot_req),
    .gun_is_connected  (gun_is_connected),
    .gun_photodetector (gun_photodetector),
    .blank_screen      (blank_screen),
    .target_white      (target_white),
    .busy              (busy),
    .hit               (hit),
    .miss              (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    conn;     // gun connected when the trigger is pulled
    bit    pd_dark;  // light on from BLACK start through end of WHITE
    int    white_n;  // clocks of light in the middle of WHITE
    bit    extra;    // second trigger during WHITE
    bit    drop;     // gun disconnected during BLACK
    bit    exp_hit;
    bit    exp_miss;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after
  // the rising edge. frame_start follows the free-running frame phase.
  task automatic step();
    @(posedge clk);
    #1;
    ph          = (ph == c_FRAME - 1) ? 0 : ph + 1;
    frame_start = (ph == 0);
    shot_req    = 1'b0;
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < c_FRAME + 1; i++) begin
      if (ph == p) break;
      step();
    end
  endtask

  // One complete shot. rc = 0 is the first frame_start after the trigger.
  task automatic run_vec(input vec_t v);
    int started, rc;
    int blank_cnt, blank_first, white_cnt, white_first;
    int hit_cnt, miss_cnt, res_rc, busy_fall, both;
    started = 0; rc = -1;
    blank_cnt = 0; blank_first = -1; white_cnt = 0; white_first = -1;
    hit_cnt = 0; miss_cnt = 0; res_rc = -1; busy_fall = -1; both = 0;

    goto_phase(50);
    gun_is_connected = v.conn;
    shot_req = 1'b1;
    step();
    chk({v.name, " busy_after_shot"}, 32'(busy), 32'(v.conn));

    for (int i = 0; i < 520; i++) begin
      if (started != 0) rc++;
      else if (frame_start) begin started = 1; rc = 0; end
      if (blank_screen) begin blank_cnt++; if (blank_first < 0) blank_first = rc; end
      if (target_white) begin white_cnt++; if (white_first < 0) white_first = rc; end
      if (hit) hit_cnt++;
      if (miss) miss_cnt++;
      if ((hit || miss) && res_rc < 0) res_rc = rc;
      if (hit && miss) both++;
      if (started != 0 && rc >= 1 && !busy && busy_fall < 0) busy_fall = rc;

      if (v.pd_dark) gun_photodetector = (started != 0) && (rc <= 200);
      else gun_photodetector = (started != 0) && (rc >= 120) && (rc < 120 + v.white_n);
      if (v.extra && rc == 150) shot_req = 1'b1;
      if (v.drop && rc == 50) gun_is_connected = 1'b0;
      step();
    end
    gun_photodetector = 1'b0;
    gun_is_connected  = 1'b1;

    chk({v.name, " blank_cnt"},   blank_cnt,   v.conn ? 100 : 0);
    chk({v.name, " blank_first"}, blank_first, v.conn ? 1 : -1);
    chk({v.name, " white_cnt"},   white_cnt,   v.conn ? 100 : 0);
    chk({v.name, " white_first"}, white_first, v.conn ? 101 : -1);
    chk({v.name, " hit_cnt"},     hit_cnt,     32'(v.exp_hit));
    chk({v.name, " miss_cnt"},    miss_cnt,    32'(v.exp_miss));
    chk({v.name, " result_time"}, res_rc,      v.conn ? 201 : -1);
    chk({v.name, " busy_fall"},   busy_fall,   v.conn ? 401 : 1);
    chk({v.name, " hit_and_miss"}, both, 0);
  endtask

  // Trigger, let the sequence reach the wanted output, then reset
  // asynchronously between clock edges.
  task automatic reset_mid(input string nm, input bit in_white);
    int res;
    int waited;
    goto_phase(50);
    shot_req = 1'b1;
    step();
    waited = 0;
    while ((in_white ? !target_white : !blank_screen) && waited < 300) begin
      step();
      waited++;
    end
    chk({nm, " reached_phase"}, 32'(waited < 300), 1);
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    chk({nm, " outs_async"}, {27'd0, blank_screen, target_white, busy, hit, miss}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    res = 0;
    for (int i = 0; i < 400; i++) begin
      if (hit || miss || busy || blank_screen || target_white) res++;
      step();
    end
    chk({nm, " quiet_after"}, res, 0);
  endtask

  initial begin
    int n, misses;
    n_chk = 0; n_fail = 0;
    ph = 1;
    rst_n = 1'b0;
    frame_start = 1'b0;
    shot_req = 1'b0;
    gun_is_connected = 1'b1;
    gun_photodetector = 1'b0;

    vecs[0] = '{"no_light",    1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"light_20",    1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"lamp",        1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"no_gun",      1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"extra_shot",  1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"light_15",    1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"light_16",    1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"unplug",      1'b1, 1'b0, 20, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) step();
    chk("reset blank_screen", 32'(blank_screen), 0);
    chk("reset target_white", 32'(target_white), 0);
    chk("reset busy",         32'(busy),         0);
    chk("reset hit",          32'(hit),          0);
    chk("reset miss",         32'(miss),         0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
    end

    reset_mid("rst_black", 1'b0);
    reset_mid("rst_white", 1'b1);
    run_vec(vecs[1]);

    // Trigger in the same cycle as frame_start: that frame_start must be
    // skipped, so blanking starts 101 clocks after the trigger cycle.
    goto_phase(0);
    chk("coinc frame_start", 32'(frame_start), 1);
    shot_req = 1'b1;
    n = 0;
    step();
    while (!blank_screen && n < 300) begin
      step();
      n++;
    end
    chk("coinc blank_delay", n + 1, 101);
    misses = 0;
    n = 0;
    while (busy && n < 600) begin
      if (miss) misses++;
      step();
      n++;
    end
    chk("coinc finished", 32'(n < 600), 1);
    chk("coinc miss_cnt", misses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
